// File: rtl/ppu_vga_pkg.sv
// Shared constants for the PPU frame store and VGA scanout.
// Timing, NES geometry, palette and handshake state encoding.
package ppu_vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int NES_W = 256;
  localparam int NES_H = 240;

  // 2C02 palette, 4 bits per channel, index 0 is leftmost
  localparam logic [0:63][11:0] NES_PAL = {
    12'h777, 12'h00F, 12'h00B, 12'h42B,
    12'h908, 12'hA02, 12'hA10, 12'h810,
    12'h530, 12'h070, 12'h060, 12'h050,
    12'h045, 12'h000, 12'h000, 12'h000,
    12'hBBB, 12'h07F, 12'h05F, 12'h64F,
    12'hD0C, 12'hE05, 12'hF30, 12'hE51,
    12'hA70, 12'h0B0, 12'h0A0, 12'h0A4,
    12'h088, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h3BF, 12'h68F, 12'h97F,
    12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
    12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9,
    12'h0ED, 12'h777, 12'h000, 12'h000,
    12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF,
    12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
    12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD,
    12'h0FF, 12'hFDF, 12'h000, 12'h000
  };

  typedef enum logic {
    ST_FREE    = 1'b0,
    ST_PENDING = 1'b1
  } swap_st_e;

endpackage

// File: rtl/ppu_vga_scanout_if.sv
// PPU pixel-write bus plus the buffer-free handshake back to the PPU.
// master = PPU render FSM, slave = scanout.
interface ppu_vga_scanout_if;
  logic [8:0] vga_row;
  logic [8:0] vga_col;
  logic [7:0] vga_data;
  logic       vga_write_en;
  logic       vga_done;

  modport master (
    output vga_row, vga_col, vga_data, vga_write_en,
    input  vga_done
  );

  modport slave (
    input  vga_row, vga_col, vga_data, vga_write_en,
    output vga_done
  );
endinterface

// File: rtl/ppu_frame_ram.sv
// Simple dual-port frame RAM: port A writes, port B reads with
// one-clock registered latency gated by its read enable.
module ppu_frame_ram #(
  parameter int AW = 17,
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  input  logic          re_b,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] dout_b
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (re_b) dout_q <= mem[addr_b];
  end

  assign dout_b = dout_q;

endmodule

// File: rtl/ppu_vga_scanout.sv
// Double-buffered NES frame store scanned out as 640x480 VGA,
// 2x2 pixel scaling, with the PPU buffer-free handshake.
module ppu_vga_scanout
  import ppu_vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_OFFSET = 64,
  parameter int V_ACT    = V_ACTIVE,
  parameter int V_FRONT  = V_FP,
  parameter int V_SYN    = V_SYNC,
  parameter int V_BACK   = V_BP
) (
  input  logic             clk,
  input  logic             rst,
  ppu_vga_scanout_if.slave ppu,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b
);

  localparam int V_TOT = V_ACT + V_FRONT + V_SYN + V_BACK;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_END = H_OFFSET + 2 * NES_W;
  localparam int HS_B  = H_ACTIVE + H_FP;
  localparam int VS_B  = V_ACT + V_FRONT;

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        act1_q, act1_d;
  logic        hs1_q, hs1_d, vs1_q, vs1_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [11:0] rgb_q, rgb_d;
  swap_st_e    st_q, st_d;
  logic        front_q, front_d;
  logic        done_q, done_d;
  logic        tick, act, hs, vs;
  logic        wr_ok, last_px;
  logic [9:0]  hcol;
  logic [16:0] raddr, waddr;
  logic [5:0]  rdata;
  logic        unused_ok;

  assign tick = div_q == DIV_W'(CLK_DIV - 1);
  assign hcol = h_q - 10'(H_OFFSET);

  assign act = (v_q < 10'(V_ACT))
            && (h_q >= 10'(H_OFFSET))
            && (h_q < 10'(H_END));
  assign hs = !((h_q >= 10'(HS_B))
             && (h_q < 10'(HS_B + H_SYNC)));
  assign vs = !((v_q >= 10'(VS_B))
             && (v_q < 10'(VS_B + V_SYN)));

  assign raddr = {front_q, v_q[8:1], hcol[8:1]};
  assign waddr = {~front_q, ppu.vga_row[7:0],
                  ppu.vga_col[7:0]};

  assign wr_ok = ppu.vga_write_en
              && (ppu.vga_row < 9'(NES_H))
              && (ppu.vga_col < 9'(NES_W))
              && (st_q == ST_FREE);
  assign last_px = (ppu.vga_row == 9'(NES_H - 1))
                && (ppu.vga_col == 9'(NES_W - 1));

  ppu_frame_ram #(.AW(17), .DW(6)) u_ram (
    .clk    (clk),
    .we_a   (wr_ok),
    .addr_a (waddr),
    .din_a  (ppu.vga_data[5:0]),
    .re_b   (tick),
    .addr_b (raddr),
    .dout_b (rdata)
  );

  // Syncs ride the same two tick stages as the RAM read + palette
  always_comb begin
    div_d  = tick ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    act1_d = act1_q;
    hs1_d  = hs1_q;
    vs1_d  = vs1_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    rgb_d  = rgb_q;
    if (tick) begin
      if (h_q == 10'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == 10'(V_TOT - 1)) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      act1_d = act;
      hs1_d  = hs;
      vs1_d  = vs;
      hs_d   = hs1_q;
      vs_d   = vs1_q;
      rgb_d  = act1_q ? NES_PAL[rdata] : '0;
    end
  end

  // A completion landing on the vblank tick waits a full frame
  always_comb begin
    st_d    = st_q;
    front_d = front_q;
    unique case (st_q)
      ST_FREE:
        if (wr_ok && last_px) st_d = ST_PENDING;
      ST_PENDING:
        if (tick && h_q == '0 && v_q == 10'(V_ACT)) begin
          st_d    = ST_FREE;
          front_d = ~front_q;
        end
    endcase
    done_d = (st_d == ST_FREE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      act1_q  <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      rgb_q   <= '0;
      st_q    <= ST_FREE;
      front_q <= 1'b0;
      done_q  <= 1'b1;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      act1_q  <= act1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      rgb_q   <= rgb_d;
      st_q    <= st_d;
      front_q <= front_d;
      done_q  <= done_d;
    end
  end

  assign ppu.vga_done = done_q;
  assign vga_hsync    = hs_q;
  assign vga_vsync    = vs_q;
  assign vga_r        = rgb_q[11:8];
  assign vga_g        = rgb_q[7:4];
  assign vga_b        = rgb_q[3:0];

  assign unused_ok = &{1'b0, ppu.vga_data[7:6],
                       hcol[9], hcol[0], v_q[9], v_q[0]};

endmodule

// File: tb/tb_ppu_vga_scanout.sv
// Scoreboard bench for ppu_vga_scanout on a short 7-line frame.
// Expected edges/pixels are queued up front; a negedge monitor checks.
module tb_ppu_vga_scanout;

  localparam int CD      = 2;
  localparam int HT      = 800;
  localparam int VT      = 7;
  localparam int FR      = HT * VT;
  localparam int END_CYC = 34000;

  typedef struct {
    int          cyc;
    int          kind;
    logic [11:0] val;
  } pt_t;

  typedef struct {
    int   cyc;
    logic lvl;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hsync, vsync;
  logic [3:0] r, g, b;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         armed = 1'b0;
  logic       hs_prev, vs_prev, dn_prev;

  pt_t pts[$];
  ev_t hs_ev[$];
  ev_t vs_ev[$];
  ev_t dn_ev[$];

  ppu_vga_scanout_if ppu_if();

  ppu_vga_scanout #(
    .CLK_DIV  (CD),
    .H_OFFSET (64),
    .V_ACT    (4),
    .V_FRONT  (1),
    .V_SYN    (1),
    .V_BACK   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ppu       (ppu_if),
    .vga_hsync (hsync),
    .vga_vsync (vsync),
    .vga_r     (r),
    .vga_g     (g),
    .vga_b     (b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic string kname(int k);
    case (k)
      0:       return "hsync";
      1:       return "vsync";
      2:       return "rgb";
      default: return "vga_done";
    endcase
  endfunction

  function automatic void pt(int c, int k, int v);
    pt_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = 12'(v);
    pts.push_back(e);
  endfunction

  // pixel (h,v) of frame f shows two ticks after the counter reaches it
  function automatic void px(int f, int h, int v, int val);
    pt(CD * (f * FR + v * HT + h + 2), 2, val);
  endfunction

  function automatic void ev(int k, int c, logic l);
    ev_t e;
    e.cyc = c;
    e.lvl = l;
    case (k)
      0:       hs_ev.push_back(e);
      1:       vs_ev.push_back(e);
      default: dn_ev.push_back(e);
    endcase
  endfunction

  function automatic void ev_chk(int k, ev_t e, logic l);
    n_cmp++;
    if (e.cyc != cyc || e.lvl != l) begin
      n_bad++;
      $display("FAIL %s edge: got level %0d at cyc %0d, want level %0d at cyc %0d",
               kname(k), l, cyc, e.lvl, e.cyc);
    end
  endfunction

  function automatic void unexp(int k, logic l);
    n_cmp++;
    n_bad++;
    $display("FAIL %s edge: got unexpected level %0d at cyc %0d, want none",
             kname(k), l, cyc);
  endfunction

  always @(negedge clk) begin : mon
    int got;
    if (armed && cyc < END_CYC) begin
      for (int i = pts.size() - 1; i >= 0; i--) begin
        if (pts[i].cyc == cyc) begin
          case (pts[i].kind)
            0:       got = int'(hsync);
            1:       got = int'(vsync);
            2:       got = int'({r, g, b});
            default: got = int'(ppu_if.vga_done);
          endcase
          n_cmp++;
          if (got != int'(pts[i].val)) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h",
                     kname(pts[i].kind), cyc, got, pts[i].val);
          end
          pts.delete(i);
        end
      end
      if (hsync !== hs_prev) begin
        if (hs_ev.size() == 0) unexp(0, hsync);
        else ev_chk(0, hs_ev.pop_front(), hsync);
      end
      if (vsync !== vs_prev) begin
        if (vs_ev.size() == 0) unexp(1, vsync);
        else ev_chk(1, vs_ev.pop_front(), vsync);
      end
      if (ppu_if.vga_done !== dn_prev) begin
        if (dn_ev.size() == 0) unexp(3, ppu_if.vga_done);
        else ev_chk(3, dn_ev.pop_front(), ppu_if.vga_done);
      end
      hs_prev = hsync;
      vs_prev = vsync;
      dn_prev = ppu_if.vga_done;
    end
  end

  task automatic wr(input int row, input int col, input int d);
    ppu_if.vga_row      = 9'(row);
    ppu_if.vga_col      = 9'(col);
    ppu_if.vga_data     = 8'(d);
    ppu_if.vga_write_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    ppu_if.vga_write_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    ppu_if.vga_row      = '0;
    ppu_if.vga_col      = '0;
    ppu_if.vga_data     = '0;
    ppu_if.vga_write_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    pt(0, 0, 1);
    pt(0, 1, 1);
    pt(0, 2, 0);
    pt(0, 3, 1);
    px(0, 63, 0, 0);
    px(0, 600, 0, 0);
    px(1, 63, 0, 0);
    px(1, 64, 0, 'h3BF);
    pt(CD * (FR + 64 + 2) + 1, 2, 'h3BF);
    px(1, 65, 0, 'h3BF);
    px(1, 66, 0, 'h3BF);
    px(1, 152, 0, 'h3BF);
    px(1, 574, 0, 'hFFF);
    px(1, 575, 0, 'hFFF);
    px(1, 576, 0, 0);
    px(1, 64, 1, 'h3BF);
    px(1, 64, 2, 'hF30);
    px(1, 575, 3, 'hF30);
    px(1, 64, 4, 0);
    px(2, 64, 0, 'h3BF);
    px(3, 64, 0, 'hF30);
    px(3, 65, 0, 'hF30);
    for (int k = 0; k < 25; k++) begin
      if (CD * (k * HT + 658) < END_CYC) ev(0, CD * (k * HT + 658), 1'b0);
      if (CD * (k * HT + 754) < END_CYC) ev(0, CD * (k * HT + 754), 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      if (CD * (k * FR + 5 * HT + 2) < END_CYC) ev(1, CD * (k * FR + 5 * HT + 2), 1'b0);
      if (CD * (k * FR + 6 * HT + 2) < END_CYC) ev(1, CD * (k * FR + 6 * HT + 2), 1'b1);
    end
    hs_prev = 1'b1;
    vs_prev = 1'b1;
    dn_prev = 1'b1;
    armed   = 1'b1;
    @(negedge clk);

    for (int c = 0; c < 256; c++)
      wr(0, c, (c == 0) ? 'hE1 : (c == 255) ? 'h30 : 'h21);
    for (int c = 0; c < 256; c++)
      wr(1, c, 'h16);
    wr(0, 300, 'h05);
    wr(0, 256, 'h05);
    wr(256, 1, 'h05);
    wr(240, 255, 'h05);
    ppu_if.vga_row      = 9'd239;
    ppu_if.vga_col      = 9'd255;
    ppu_if.vga_write_en = 1'b0;
    @(negedge clk);
    ev(3, cyc + 1, 1'b0);
    ev(3, CD * (4 * HT + 1), 1'b1);
    wr(239, 255, 'h21);
    wr(0, 0, 'h05);
    idle();

    wait_cyc(7000);
    wr(0, 0, 'h16);
    idle();

    wait_cyc(CD * (FR + 4 * HT) + 1);
    ev(3, cyc + 1, 1'b0);
    ev(3, CD * (2 * FR + 4 * HT + 1), 1'b1);
    wr(239, 255, 'h21);
    wr(0, 0, 'h05);
    idle();

    wait_cyc(END_CYC);
    foreach (pts[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s @cyc %0d: got no sample, want %0h",
               kname(pts[i].kind), pts[i].cyc, pts[i].val);
    end
    foreach (hs_ev[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL hsync edge: got none, want level %0d at cyc %0d",
               hs_ev[i].lvl, hs_ev[i].cyc);
    end
    foreach (vs_ev[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL vsync edge: got none, want level %0d at cyc %0d",
               vs_ev[i].lvl, vs_ev[i].cyc);
    end
    foreach (dn_ev[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL vga_done edge: got none, want level %0d at cyc %0d",
               dn_ev[i].lvl, dn_ev[i].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
